// File: rtl/adder_pkg.sv
// Shared constants, slice helper and per-stage sideband bundle for the pipelined CLA adder.
package adder_pkg;

    localparam int CLA_GRP = 4;

    typedef struct packed {
        logic vld;
        logic carry;
        logic sub;
        logic sat;
    } sband_t;

    function automatic int slice_lo(input int k, input int sw);
        return k * sw;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit carry-lookahead cell: slice sum plus group generate/propagate.
module cla_group4
    import adder_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               c_in,
    output logic [CLA_GRP-1:0] s,
    output logic               g,
    output logic               p
);

    logic [CLA_GRP-1:0] gi;
    logic [CLA_GRP-1:0] pi;
    logic [CLA_GRP-1:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[0] = c_in;
    assign c[1] = gi[0] | (pi[0] & c_in);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c_in);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & c_in);

    assign s = pi ^ c;
    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES slice per stage with valid/ready flow.
// Optional saturation on signed overflow is built only when ADDER_SAT_EN is defined.
module pipe_cla_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / CLA_GRP;
    localparam int NGRP = WIDTH / CLA_GRP;

    logic             adv;
    logic             sat0;

    sband_t           sb_p  [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];

    sband_t           st_sb   [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_sum  [STAGES];
    logic [WIDTH-1:0] nxt_sum [STAGES];
    logic [STAGES-1:0] st_cin;
    logic [STAGES-1:0] st_cout;

    logic [WIDTH-1:0] cla_a;
    logic [WIDTH-1:0] cla_b;
    logic [WIDTH-1:0] cla_s;

    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] fin_sum;
    logic             fin_ovf;

`ifdef ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign sat0 = in_sat;
`else
    logic unused_sat;
    assign unused_sat = in_sat;
    assign sat0       = 1'b0;
`endif

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    // Stage inputs: stage 0 from the ports, stage k from the registers of stage k-1.
    always_comb begin
        st_sb[0]  = '{vld: in_valid, carry: (in_sub ? 1'b1 : in_cin), sub: in_sub, sat: sat0};
        st_a[0]   = in_a;
        st_b[0]   = in_b ^ {WIDTH{in_sub}};
        st_sum[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_sb[k]  = sb_p[k-1];
            st_a[k]   = a_p[k-1];
            st_b[k]   = b_p[k-1];
            st_sum[k] = sum_p[k-1];
        end
        cla_a  = '0;
        cla_b  = '0;
        st_cin = '0;
        for (int k = 0; k < STAGES; k++) begin
            cla_a[slice_lo(k, SW) +: SW] = st_a[k][slice_lo(k, SW) +: SW];
            cla_b[slice_lo(k, SW) +: SW] = st_b[k][slice_lo(k, SW) +: SW];
            st_cin[k]                    = st_sb[k].carry;
        end
    end

    // Carries cascade only between the groups of one slice; each slice head takes its stage carry.
    for (genvar i = 0; i < NGRP; i++) begin : g_grp
        logic g;
        logic p;
        logic cin;
        logic cout;

        if (i % NG == 0) begin : g_head
            assign cin = st_cin[i / NG];
        end else begin : g_link
            assign cin = g_grp[i-1].cout;
        end

        assign cout = g | (p & cin);

        cla_group4 u_cla (
            .a    (cla_a[i*CLA_GRP +: CLA_GRP]),
            .b    (cla_b[i*CLA_GRP +: CLA_GRP]),
            .c_in (cin),
            .s    (cla_s[i*CLA_GRP +: CLA_GRP]),
            .g    (g),
            .p    (p)
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_cout
        assign st_cout[k] = g_grp[k*NG + NG - 1].cout;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_sum[k]                        = st_sum[k];
            nxt_sum[k][slice_lo(k, SW) +: SW] = cla_s[slice_lo(k, SW) +: SW];
        end
        a_msb   = cla_a[WIDTH-1];
        b_msb   = cla_b[WIDTH-1];
        raw_sum = nxt_sum[STAGES-1];
        fin_ovf = (a_msb == b_msb) & (raw_sum[WIDTH-1] != a_msb);
        fin_sum = raw_sum;
`ifdef ADDER_SAT_EN
        if (st_sb[STAGES-1].sat && fin_ovf) begin
            fin_sum = sat_value(a_msb);
        end
`endif
    end

    // Stage registers: sideband and the output stage are reset, operand/sum slices are not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sb_p[k] <= '0;
            end
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES-1; k++) begin
                sb_p[k] <= '{vld: st_sb[k].vld, carry: st_cout[k], sub: st_sb[k].sub, sat: st_sb[k].sat};
            end
            out_valid <= st_sb[STAGES-1].vld;
            out_sum   <= fin_sum;
            out_cout  <= st_cout[STAGES-1];
            out_ovf   <= fin_ovf;
            out_zero  <= (fin_sum == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES-1; k++) begin
                a_p[k]   <= st_a[k];
                b_p[k]   <= st_b[k];
                sum_p[k] <= nxt_sum[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder: 32-bit/4-stage instance plus an 8-bit/1-stage instance.
module tb_pipe_cla_adder;

`ifdef ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif
    localparam int STAGES = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic        sat;
        logic [34:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_cin, in_sub, in_sat;
    logic [31:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;

    logic        d1_in_valid, d1_in_ready, d1_in_cin, d1_in_sub, d1_in_sat;
    logic [7:0]  d1_in_a, d1_in_b, d1_out_sum;
    logic        d1_out_valid, d1_out_ready, d1_out_cout, d1_out_ovf, d1_out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(32), .STAGES(STAGES)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    pipe_cla_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .in_cin(d1_in_cin), .in_sub(d1_in_sub), .in_sat(d1_in_sat),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .out_sum(d1_out_sum), .out_cout(d1_out_cout), .out_ovf(d1_out_ovf), .out_zero(d1_out_zero)
    );

    // Reference: plain integer add with one extra bit for the carry.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub, input logic sat);
        logic [32:0] full;
        logic [31:0] bb;
        res_t        r;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (a[31] == bb[31]) && (r.sum[31] != a[31]);
        if (SAT_BUILD && sat && r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic sub, input logic sat);
        logic [8:0] full;
        logic [7:0] bb, s;
        logic       ov;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, (sub ? 1'b1 : cin)};
        s    = full[7:0];
        ov   = (a[7] == bb[7]) && (s[7] != a[7]);
        if (SAT_BUILD && sat && ov) s = a[7] ? 8'h80 : 8'h7F;
        return {s, full[8], ov, (s == 8'd0)};
    endfunction

    // Issues one beat into an idle pipe and waits (bounded) for its result.
    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sub, input logic sat, output logic [34:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_sat = sat;
        out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = {out_sum, out_cout, out_ovf, out_zero};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_sat = 1'b0;
        out_ready = 1'b1;
        d1_in_valid = 1'b0; d1_in_a = '0; d1_in_b = '0; d1_in_cin = 1'b0; d1_in_sub = 1'b0;
        d1_in_sat = 1'b0; d1_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero});
        end
        n_tests++;
        if ({d1_out_valid, d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs_d1: got %h required 0",
                     {d1_out_valid, d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t        v[$];
        logic [34:0] got;
        int          lat;
        v.push_back('{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1}});
        v.push_back('{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0}});
        v.push_back('{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1,
                      SAT_BUILD ? {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0} : {32'h8000_0000, 1'b0, 1'b1, 1'b0}});
        v.push_back('{32'h5, 32'h7, 1'b0, 1'b1, 1'b0, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}});
        v.push_back('{32'h7, 32'h5, 1'b1, 1'b1, 1'b0, {32'h0000_0002, 1'b1, 1'b0, 1'b0}});
        v.push_back('{32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, {32'h0001_0000, 1'b0, 1'b0, 1'b0}});
        v.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1,
                      SAT_BUILD ? {32'h8000_0000, 1'b1, 1'b1, 1'b0} : {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}});
        v.push_back('{32'h0, 32'h0, 1'b1, 1'b0, 1'b0, {32'h0000_0001, 1'b0, 1'b0, 1'b0}});
        v.push_back('{32'h5, 32'h5, 1'b0, 1'b1, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1}});
        v.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1,
                      SAT_BUILD ? {32'h8000_0000, 1'b1, 1'b1, 1'b0} : {32'h0000_0000, 1'b1, 1'b1, 1'b1}});
        v.push_back('{32'h00FF_00FF, 32'h0000_FF01, 1'b0, 1'b0, 1'b0, {32'h0100_0000, 1'b0, 1'b0, 1'b0}});
        foreach (v[i]) begin
            issue0(v[i].a, v[i].b, v[i].cin, v[i].sub, v[i].sat, got, lat);
            n_tests++;
            if (lat != STAGES) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, STAGES);
            end
            n_tests++;
            if (got !== v[i].exp) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got sum/cout/ovf/zero %h required %h", i, got, v[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t        expq[$];
        res_t        e;
        logic [34:0] snap;
        logic [31:0] a, b;
        logic        cin, sub, sat;
        bit          have_snap = 1'b0;
        int          sent = 0, got = 0, cyc = 0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
        while (got < 16 && cyc < 200) begin
            @(negedge clk);
            out_ready = !(cyc >= 8 && cyc < 13);
            if (sent < 16) begin
                in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_sat = sat;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready[cyc %0d]: got %b required 0", cyc, in_ready);
                end
                if (have_snap) begin
                    n_tests++;
                    if ({out_sum, out_cout, out_ovf, out_zero} !== snap || out_valid !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold[cyc %0d]: got %h/%b required %h/1", cyc,
                                 {out_sum, out_cout, out_ovf, out_zero}, out_valid, snap);
                    end
                end
                snap      = {out_sum, out_cout, out_ovf, out_zero};
                have_snap = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra[cyc %0d]: got result %h required none", cyc, out_sum);
                end else begin
                    e = expq.pop_front();
                    if ({out_sum, out_cout, out_ovf, out_zero} !== e) begin
                        n_fail++;
                        $display("FAIL stream_result[%0d]: got %h required %h", got,
                                 {out_sum, out_cout, out_ovf, out_zero}, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, cin, sub, sat));
                sent++;
                a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); sat = 1'($urandom);
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_tests++;
        if (got != 16 || sent != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results from %0d beats, required 16", got, sent);
        end
    endtask

    task automatic test_reset_midflight();
        logic [34:0] got;
        int          lat, waitc;
        bit          stale;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'(i + 100); in_b = 32'(i * 7); in_cin = 1'b0;
            in_sub = 1'b0; in_sat = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        waitc = 0;
        while (!out_valid && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_prefill: got out_valid %b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'd0) begin
            n_fail++;
            $display("FAIL midflight_reset_clear: got %h required 0",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero});
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL midflight_stale: got out_valid 1 after reset required 0");
        end
        issue0(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, got, lat);
        n_tests++;
        if (lat != STAGES || got !== {32'd3, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midflight_first_beat: got %h lat %0d required %h lat %0d", got, lat,
                     {32'd3, 1'b0, 1'b0, 1'b0}, STAGES);
        end
    endtask

    task automatic test_single_stage();
        logic [10:0] exp_q[$];
        logic [10:0] e;
        logic [7:0]  a, b;
        logic        cin, sub, sat;
        @(negedge clk);
        d1_out_ready = 1'b1;
        d1_in_valid = 1'b1; d1_in_a = 8'h80; d1_in_b = 8'h80; d1_in_cin = 1'b0;
        d1_in_sub = 1'b0; d1_in_sat = 1'b0;
        @(negedge clk);
        d1_in_valid = 1'b0;
        n_tests++;
        if (d1_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL s1_latency: got out_valid %b one cycle after accept required 1", d1_out_valid);
        end
        n_tests++;
        if ({d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL s1_80p80: got %h required %h",
                     {d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero}, {8'h00, 1'b1, 1'b1, 1'b1});
        end
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (d1_out_valid !== 1'b1 || {d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero} !== e) begin
                    n_fail++;
                    $display("FAIL s1_stream[%0d]: got %b/%h required 1/%h", i - 1, d1_out_valid,
                             {d1_out_sum, d1_out_cout, d1_out_ovf, d1_out_zero}, e);
                end
            end
            if (i < 8) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                sat = 1'($urandom);
                d1_in_valid = 1'b1; d1_in_a = a; d1_in_b = b; d1_in_cin = cin;
                d1_in_sub = sub; d1_in_sat = sat;
                exp_q.push_back(model8(a, b, cin, sub, sat));
            end else begin
                d1_in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_single_stage();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
Name: pipe_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. Operands of WIDTH bits are split into STAGES equal slices. Each pipeline stage resolves one slice using 4-bit lookahead groups and hands its carry to the next stage. Valid/ready handshakes on both sides allow back-to-back issue and downstream backpressure.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of 4*STAGES.
STAGES, 4, pipeline stages; slice width SW = WIDTH/STAGES; latency = STAGES cycles.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat this cycle.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_cin  in  1  carry-in for add; ignored for sub.
in_sub  in  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
in_sat  in  1  saturate request; honoured only with ADDER_SAT_EN.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_sum  out  WIDTH  result.
out_cout  out  1  carry out of MSB; for sub, 1 = no borrow.
out_ovf  out  1  signed overflow.
out_zero  out  1  out_sum == 0.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: all stage valid bits, out_valid, out_sum, out_cout, out_ovf and out_zero = 0. After release, in_ready=1.
- Global advance: adv = !out_valid | out_ready; in_ready = adv. Every pipeline register loads only when adv=1.
- A beat is accepted when in_valid & in_ready.
- Stage k (0..STAGES-1) computes bits [k*SW +: SW] from skewed operands and the carry registered by stage k-1.
  - Stage 0 carry = in_sub ? 1 : in_cin.
  - B is inverted when in_sub=1.
  - Within a slice, carries come from SW/4 cascaded 4-bit lookahead groups (group generate/propagate). There is no ripple across the full width inside one cycle.
- Upper operand slices are delayed k cycles and lower sum slices are delayed (STAGES-1-k) cycles, so all slices of one beat present together. Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays 1.
- Throughput is one beat per cycle with no bubbles.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. Data registers may load don't-care values, but a valid bit never sets spuriously.
- out_ovf = (a_msb == b'_msb) & (sum_msb != a_msb), where b' is B after the sub inversion.
- out_zero is computed from the final sum, after saturation if enabled.
- Backpressure: when out_valid=1 and out_ready=0, the whole pipe freezes, all outputs hold stable, and in_ready=0. No beat is lost or duplicated.
- Wrap: results are modulo 2^WIDTH, with out_cout carrying bit WIDTH.
- Reset mid-operation: all in-flight beats are discarded. The first beat after reset sees carry state 0.

Optional Feature:
Macro ADDER_SAT_EN.
- Defined: when in_sat=1 and out_ovf=1, out_sum = sign(a) ? {1'b1,{WIDTH-1{1'b0}}} : {1'b0,{WIDTH-1{1'b1}}}. out_ovf still reports 1 and out_cout is unchanged. The in_sat bit travels with its beat through the pipe.
- Undefined: in_sat is ignored, no saturation logic is built, and results wrap.

Decomposition:
- Package adder_pkg holds:
  - CLA_GRP = 4;
  - function slice_lo(k, SW);
  - typedef of the per-stage carry/valid/sub/sat sideband bundle.
- One sub-module, cla_group4: a combinational 4-bit lookahead cell (inputs a, b, c_in; outputs s[3:0], group G, group P). It is instantiated WIDTH/4 times.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1: A=FFFFFFFF, B=1, cin=0, sub=0 -> 4 cycles later sum=00000000, cout=1, zero=1, ovf=0.
- A=7FFFFFFF + B=1 -> sum=80000000, ovf=1, cout=0. With ADDER_SAT_EN and sat=1: sum=7FFFFFFF, ovf=1.
- Sub: A=5, B=7 -> sum=FFFFFFFE, cout=0. A=7, B=5 -> sum=2, cout=1. Cross-slice carry: A=0000FFFF + B=1 -> 00010000.
- Stream 16 random beats back-to-back, then hold out_ready=0 for 5 cycles mid-stream. Required: in_ready=0 during the stall, outputs stable, all 16 results in order and matching the reference model.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately and no stale result after release. The next beat 1+2 yields 3 after 4 cycles.
- STAGES=1, WIDTH=8: 80+80 -> sum=00, cout=1, ovf=1, latency 1 cycle.
